// File: rtl/hazard_unit_fwd.sv
// -----------------------------------------------------------------------------
// hazard_unit_fwd
//
// RAW hazard and forwarding controller for the in-order pipeline. A shadow
// pipeline follows every in-flight destination register behind ID; the
// instruction currently in ID is compared against it to decide whether it
// stalls (with a bubble into ID/EX) or picks its operands from a later stage.
// A taken branch/jump in EX raises flush for the redirect cycle plus
// FLUSH_CYCLES further cycles; flush overrides every other decision.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   id_valid                 ID holds a real instruction
//   id_rs / id_rt            source register indices
//   id_rs_used / id_rt_used  the instruction actually reads rs / rt
//   id_rd, id_wr_en          destination index and its write enable
//   id_is_load               destination is only ready at the end of MEM
//   ex_redirect              branch/jump resolved taken in EX
//   stall                    hold PC and IF/ID
//   bubble                   insert a NOP into ID/EX (always equals stall)
//   flush                    squash IF/ID
//   fwd_rs_sel / fwd_rt_sel  0 = regfile, k = value from tracked stage k
//   stall_count              saturating number of stall cycles since reset
// -----------------------------------------------------------------------------
module hazard_unit_fwd #(
    parameter int REG_AW       = 3,
    parameter int DEPTH        = 4,
    parameter int FWD_EN       = 1,
    parameter int BYPASS_WB    = 1,
    parameter int R0_ZERO      = 0,
    parameter int FLUSH_CYCLES = 1,
    parameter int SW           = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wr_en,
    input  logic              id_is_load,
    input  logic              ex_redirect,
    output logic              stall,
    output logic              bubble,
    output logic              flush,
    output logic [SW-1:0]     fwd_rs_sel,
    output logic [SW-1:0]     fwd_rt_sel,
    output logic [15:0]       stall_count
);

    // Deepest stage that can still cause a hazard. With regfile write-through
    // the WB stage is invisible to ID, so its entry is never consulted and is
    // not kept at all.
    localparam int LAST = DEPTH - BYPASS_WB;

    // Tracker: entry 1 is EX, entry k is k stages after ID.
    logic [LAST:1]     trk_v;
    logic [REG_AW-1:0] trk_rd [1:LAST];
    // Only the EX entry's load flag matters: a load in MEM or later has its
    // data and forwards like any other producer.
    logic              trk_ld1;

    logic [LAST:1] rs_hit;
    logic [LAST:1] rt_hit;
    logic          rs_zero_blk;
    logic          rt_zero_blk;
    logic          raw_stall;
    logic [SW-1:0] rs_sel_raw;
    logic [SW-1:0] rt_sel_raw;
    logic [1:0]    flush_cnt;
    logic          enter_v;

    // -------------------------------------------------------------------------
    // Hazard detection and forward-select generation
    // -------------------------------------------------------------------------
    assign rs_zero_blk = (R0_ZERO != 0) && (id_rs == '0);
    assign rt_zero_blk = (R0_ZERO != 0) && (id_rt == '0);

    always_comb begin
        // NOTE: every output of a combinational block gets a default before any
        // conditional code, otherwise an untaken path would infer a latch.
        rs_hit     = '0;
        rt_hit     = '0;
        raw_stall  = 1'b0;
        rs_sel_raw = '0;
        rt_sel_raw = '0;

        for (int k = 1; k <= LAST; k++) begin
            rs_hit[k] = id_valid & id_rs_used & trk_v[k] & (trk_rd[k] == id_rs) & ~rs_zero_blk;
            rt_hit[k] = id_valid & id_rt_used & trk_v[k] & (trk_rd[k] == id_rt) & ~rt_zero_blk;
        end

        if (FWD_EN != 0) begin
            // Walk from oldest to youngest so the youngest producer wins.
            for (int k = LAST; k >= 1; k--) begin
                if (rs_hit[k]) rs_sel_raw = SW'(k);
                if (rt_hit[k]) rt_sel_raw = SW'(k);
            end
            raw_stall = trk_ld1 & (rs_hit[1] | rt_hit[1]);
        end else begin
            for (int k = 1; k <= LAST; k++) begin
                raw_stall = raw_stall | rs_hit[k] | rt_hit[k];
            end
        end
    end

    // Flush overrides stall and forwarding; reset forces everything quiet.
    assign flush      = ~rst & ((flush_cnt != 2'd0) | ex_redirect);
    assign stall      = raw_stall & ~flush;
    assign bubble     = stall;
    assign fwd_rs_sel = flush ? '0 : rs_sel_raw;
    assign fwd_rt_sel = flush ? '0 : rt_sel_raw;

    // A stalled or flushed ID instruction does not advance, so a bubble enters.
    assign enter_v = id_valid & id_wr_en & ~stall & ~flush;

    // -------------------------------------------------------------------------
    // Tracker valid bits and load flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state is always written with non-blocking <= so every
        // register samples the pre-edge value, independent of statement order.
        if (rst) begin
            trk_v   <= '0;
            trk_ld1 <= 1'b0;
        end else begin
            trk_v[1] <= enter_v;
            for (int k = 2; k <= LAST; k++) begin
                trk_v[k] <= trk_v[k-1];
            end
            trk_ld1 <= id_is_load;
        end
    end

    // NOTE: the destination-index array is deliberately left without reset;
    // it is only ever qualified by its valid bit, which is reset.
    always_ff @(posedge clk) begin
        trk_rd[1] <= id_rd;
        for (int k = 2; k <= LAST; k++) begin
            trk_rd[k] <= trk_rd[k-1];
        end
    end

    // -------------------------------------------------------------------------
    // Flush counter: a redirect (re)loads it, otherwise it counts down to zero.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt <= 2'd0;
        end else if (ex_redirect) begin
            flush_cnt <= 2'(FLUSH_CYCLES);
        end else if (flush_cnt != 2'd0) begin
            flush_cnt <= flush_cnt - 2'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Saturating stall-cycle counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= 16'd0;
        end else if (stall && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_unit_fwd.sv
// -----------------------------------------------------------------------------
// Bench for hazard_unit_fwd. Three instances share one set of ID inputs:
//   dut 0: defaults (forwarding, FLUSH_CYCLES=1)
//   dut 1: FWD_EN=0 (stall-only)
//   dut 2: R0_ZERO=1, FLUSH_CYCLES=2
// Stimulus is driven 1 ns after the rising edge; each expected response is
// queued with its cycle stamp and a monitor compares at the falling edge.
// -----------------------------------------------------------------------------
module tb_hazard_unit_fwd;

    localparam int AW = 3;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic          id_rs_used;
    logic          id_rt_used;
    logic [AW-1:0] id_rd;
    logic          id_wr_en;
    logic          id_is_load;
    logic          ex_redirect;

    logic [2:0]         stall_o;
    logic [2:0]         bubble_o;
    logic [2:0]         flush_o;
    logic [2:0][SW-1:0] rs_sel_o;
    logic [2:0][SW-1:0] rt_sel_o;
    logic [2:0][15:0]   cnt_o;

    hazard_unit_fwd #(.FWD_EN(1)) u_dut0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd),
        .id_wr_en(id_wr_en), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
        .stall(stall_o[0]), .bubble(bubble_o[0]), .flush(flush_o[0]),
        .fwd_rs_sel(rs_sel_o[0]), .fwd_rt_sel(rt_sel_o[0]), .stall_count(cnt_o[0])
    );

    hazard_unit_fwd #(.FWD_EN(0)) u_dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd),
        .id_wr_en(id_wr_en), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
        .stall(stall_o[1]), .bubble(bubble_o[1]), .flush(flush_o[1]),
        .fwd_rs_sel(rs_sel_o[1]), .fwd_rt_sel(rt_sel_o[1]), .stall_count(cnt_o[1])
    );

    hazard_unit_fwd #(.R0_ZERO(1), .FLUSH_CYCLES(2)) u_dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd),
        .id_wr_en(id_wr_en), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
        .stall(stall_o[2]), .bubble(bubble_o[2]), .flush(flush_o[2]),
        .fwd_rs_sel(rs_sel_o[2]), .fwd_rt_sel(rt_sel_o[2]), .stall_count(cnt_o[2])
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        int            dut;
        string         tag;
        logic          stall;
        logic          flush;
        logic [SW-1:0] rs_sel;
        logic [SW-1:0] rt_sel;
        logic [15:0]   cnt;
        bit            chk_cnt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------ monitor
    exp_t mon_e;
    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            if (mon_e.cyc != cyc) begin
                check({mon_e.tag, "_stamp"}, mon_e.cyc, cyc);
            end else begin
                check({mon_e.tag, "_stall"},  int'(stall_o[mon_e.dut]),  int'(mon_e.stall));
                check({mon_e.tag, "_bubble"}, int'(bubble_o[mon_e.dut]), int'(mon_e.stall));
                check({mon_e.tag, "_flush"},  int'(flush_o[mon_e.dut]),  int'(mon_e.flush));
                check({mon_e.tag, "_rs_sel"}, int'(rs_sel_o[mon_e.dut]), int'(mon_e.rs_sel));
                check({mon_e.tag, "_rt_sel"}, int'(rt_sel_o[mon_e.dut]), int'(mon_e.rt_sel));
                if (mon_e.chk_cnt)
                    check({mon_e.tag, "_count"}, int'(cnt_o[mon_e.dut]), int'(mon_e.cnt));
            end
        end
    end

    // ------------------------------------------------------------ stimulus side
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit v, input int rs, input int rt, input bit ru, input bit tu,
                          input int rd, input bit we, input bit ld, input bit redir);
        id_valid    = v;
        id_rs       = AW'(rs);
        id_rt       = AW'(rt);
        id_rs_used  = ru;
        id_rt_used  = tu;
        id_rd       = AW'(rd);
        id_wr_en    = we;
        id_is_load  = ld;
        ex_redirect = redir;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic exp_push(input int dut, input string tag, input bit st, input bit fl,
                            input int rs, input int rt, input int cnt, input bit cc);
        exp_t e;
        e.cyc     = cyc;
        e.dut     = dut;
        e.tag     = tag;
        e.stall   = st;
        e.flush   = fl;
        e.rs_sel  = SW'(rs);
        e.rt_sel  = SW'(rt);
        e.cnt     = 16'(cnt);
        e.chk_cnt = cc;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        next_cycle();
        rst = 1'b1;
        idle();
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();

        // Reset state of every instance.
        next_cycle();
        for (int d = 0; d < 3; d++) exp_push(d, "reset", 0, 0, 0, 0, 0, 1);
        next_cycle();
        rst = 1'b0;

        // Forwarding from EX, then from MEM.
        do_reset();
        next_cycle(); set_in(1, 0, 0, 0, 0, 1, 1, 0, 0); exp_push(0, "p1_prod", 0, 0, 0, 0, 0, 1);
        next_cycle(); set_in(1, 1, 0, 1, 0, 0, 0, 0, 0); exp_push(0, "p1_fwd1", 0, 0, 1, 0, 0, 1);
        next_cycle();                                    exp_push(0, "p1_fwd2", 0, 0, 2, 0, 0, 1);

        // Load-use: one stall cycle, then forward from MEM.
        do_reset();
        next_cycle(); set_in(1, 0, 0, 0, 0, 2, 1, 1, 0); exp_push(0, "p2_load",  0, 0, 0, 0, 0, 1);
        next_cycle(); set_in(1, 0, 2, 0, 1, 0, 0, 0, 0); exp_push(0, "p2_lu",    1, 0, 0, 1, 0, 1);
        next_cycle();                                    exp_push(0, "p2_after", 0, 0, 0, 2, 1, 1);
        next_cycle(); idle();                            exp_push(0, "p2_idle",  0, 0, 0, 0, 1, 1);

        // Stall-only instance: three stall cycles, then released.
        do_reset();
        next_cycle(); set_in(1, 0, 0, 0, 0, 3, 1, 0, 0); exp_push(1, "p3_prod", 0, 0, 0, 0, 0, 1);
        next_cycle(); set_in(1, 3, 0, 1, 0, 0, 0, 0, 0); exp_push(1, "p3_st1",  1, 0, 0, 0, 0, 1);
        next_cycle();                                    exp_push(1, "p3_st2",  1, 0, 0, 0, 1, 1);
        next_cycle();                                    exp_push(1, "p3_st3",  1, 0, 0, 0, 2, 1);
        next_cycle();                                    exp_push(1, "p3_go",   0, 0, 0, 0, 3, 1);

        // Back-to-back writers of r4: youngest wins on both operands.
        do_reset();
        next_cycle(); set_in(1, 0, 0, 0, 0, 4, 1, 0, 0);
        next_cycle();
        next_cycle(); set_in(1, 4, 4, 1, 1, 0, 0, 0, 0);
        exp_push(0, "p4_r4_d0", 0, 0, 1, 1, 0, 1);
        exp_push(2, "p4_r4_d2", 0, 0, 1, 1, 0, 1);

        // Same on r0: suppressed only where R0_ZERO=1.
        do_reset();
        next_cycle(); set_in(1, 0, 0, 0, 0, 0, 1, 0, 0);
        next_cycle();
        next_cycle(); set_in(1, 0, 0, 1, 1, 0, 0, 0, 0);
        exp_push(0, "p4_r0_d0", 0, 0, 1, 1, 0, 1);
        exp_push(2, "p4_r0_d2", 0, 0, 0, 0, 0, 1);

        // Redirect during a load-use stall; dut2 flushes 3 cycles, dut0 2 cycles.
        do_reset();
        next_cycle(); set_in(1, 0, 0, 0, 0, 2, 1, 1, 0);
        next_cycle(); set_in(1, 0, 2, 0, 1, 0, 0, 0, 1);
        exp_push(2, "p5_redir_d2", 0, 1, 0, 0, 0, 1);
        exp_push(0, "p5_redir_d0", 0, 1, 0, 0, 0, 1);
        next_cycle(); set_in(1, 0, 2, 0, 1, 5, 1, 0, 0);
        exp_push(2, "p5_fl1_d2", 0, 1, 0, 0, 0, 1);
        exp_push(0, "p5_fl1_d0", 0, 1, 0, 0, 0, 1);
        next_cycle();
        exp_push(2, "p5_fl2_d2", 0, 1, 0, 0, 0, 1);
        exp_push(0, "p5_fl2_d0", 0, 0, 0, 3, 0, 1);
        next_cycle(); set_in(1, 5, 5, 1, 1, 0, 0, 0, 0);
        exp_push(2, "p5_end_d2", 0, 0, 0, 0, 0, 1);
        exp_push(0, "p5_end_d0", 0, 0, 1, 1, 0, 1);

        // Asynchronous reset in the middle of a stall, with a redirect present.
        do_reset();
        next_cycle(); set_in(1, 0, 0, 0, 0, 3, 1, 0, 0);
        next_cycle(); set_in(1, 3, 0, 1, 0, 0, 0, 0, 0); exp_push(1, "p6_st1", 1, 0, 0, 0, 0, 1);
        next_cycle(); set_in(1, 3, 0, 1, 0, 0, 0, 0, 1);
        #1 rst = 1'b1;
        exp_push(1, "p6_arst_d1", 0, 0, 0, 0, 0, 1);
        exp_push(0, "p6_arst_d0", 0, 0, 0, 0, 0, 1);
        next_cycle(); rst = 1'b0; set_in(1, 3, 0, 1, 0, 0, 0, 0, 0);
        exp_push(1, "p6_post_d1", 0, 0, 0, 0, 0, 1);
        exp_push(0, "p6_post_d0", 0, 0, 0, 0, 0, 1);

        next_cycle(); idle();
        next_cycle();
        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
